// File: rtl/poly1305_block_feeder.sv
// Poly1305 block feeder: packs a 32-bit AAD/payload word stream into 128-bit
// blocks with byte keep masks, paces one outstanding block at a time on the
// MAC core's done pulses, and finishes each frame with the length block.
// Optional build macro: POLY_FEEDER_TIMEOUT_EN enables a done-wait timeout
// (TIMEOUT_CYCLES) that aborts the frame with an err pulse.
//
// state    | meaning
// IDLE     | waiting for start
// AAD_FILL | accepting AAD words into the block buffer
// AAD_SEND | presenting AAD block, waiting for aad_ready
// AAD_WAIT | waiting for aad_done
// PLD_FILL | accepting payload words into the block buffer
// PLD_SEND | presenting payload block, waiting for pld_ready
// PLD_WAIT | waiting for pld_done
// LEN_SEND | presenting length block, waiting for len_ready
// LEN_WAIT | waiting for lens_done
module poly1305_block_feeder #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         s_valid,
   input  logic [31:0]  s_data,
   input  logic [3:0]   s_keep,
   input  logic         s_last,
   output logic         s_ready,
   output logic         mac_start,
   output logic         aad_valid,
   output logic [127:0] aad_data,
   output logic [15:0]  aad_keep,
   input  logic         aad_ready,
   input  logic         aad_done,
   output logic         pld_valid,
   output logic [127:0] pld_data,
   output logic [15:0]  pld_keep,
   input  logic         pld_ready,
   input  logic         pld_done,
   output logic         len_valid,
   output logic [127:0] len_block,
   input  logic         len_ready,
   input  logic         lens_done,
   output logic         busy,
   output logic         frame_done,
   output logic         err
);

   typedef enum logic [3:0] {
      IDLE, AAD_FILL, AAD_SEND, AAD_WAIT, PLD_FILL, PLD_SEND, PLD_WAIT, LEN_SEND, LEN_WAIT
   } state_t;

   state_t        state_q, state_d;
   logic [127:0]  buf_q, buf_fill;
   logic [4:0]    fill_cnt, cnt_next, lane;
   logic [63:0]   aad_len, pld_len;
   logic [2:0]    pop;
   logic [16:0]   keep_wide;
   logic [15:0]   keep_mask;
   logic          last_seen, mac_start_q, frame_done_q;
   logic          in_fill, accept, close, empty_close, timeout;

   assign in_fill     = (state_q == AAD_FILL) || (state_q == PLD_FILL);
   assign s_ready     = in_fill && (fill_cnt < 5'd16);
   assign accept      = s_valid && s_ready;
   assign pop         = 3'(s_keep[0]) + 3'(s_keep[1]) + 3'(s_keep[2]) + 3'(s_keep[3]);
   assign cnt_next    = fill_cnt + {2'b00, pop};
   assign close       = accept && (s_last || (cnt_next >= 5'd16));
   assign empty_close = close && (cnt_next == 5'd0);
   assign keep_wide   = (17'd1 << fill_cnt) - 17'd1;
   assign keep_mask   = keep_wide[15:0];

   // Merge the incoming word's enabled bytes into the buffer at byte offset fill_cnt.
   always_comb begin
      buf_fill = buf_q;
      lane     = '0;
      for (int i = 0; i < 4; i++) begin
         lane = fill_cnt + 5'(i);
         if (s_keep[i] && (lane < 5'd16))
            buf_fill[{lane[3:0], 3'b000} +: 8] = s_data[i*8 +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; a timeout overrides whatever the WAIT state would do.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (start)     state_d = AAD_FILL;
         AAD_FILL: if (close)     state_d = empty_close ? PLD_FILL : AAD_SEND;
         AAD_SEND: if (aad_ready) state_d = AAD_WAIT;
         AAD_WAIT: if (aad_done)  state_d = last_seen ? PLD_FILL : AAD_FILL;
         PLD_FILL: if (close)     state_d = empty_close ? LEN_SEND : PLD_SEND;
         PLD_SEND: if (pld_ready) state_d = PLD_WAIT;
         PLD_WAIT: if (pld_done)  state_d = last_seen ? LEN_SEND : PLD_FILL;
         LEN_SEND: if (len_ready) state_d = LEN_WAIT;
         LEN_WAIT: if (lens_done) state_d = IDLE;
         default:                 state_d = IDLE;
      endcase
      if (timeout) state_d = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         buf_q        <= '0;
         fill_cnt     <= '0;
         aad_len      <= '0;
         pld_len      <= '0;
         last_seen    <= 1'b0;
         mac_start_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         mac_start_q  <= (state_q == IDLE) && start;
         frame_done_q <= (state_q == LEN_WAIT) && lens_done;
         if (((state_q == IDLE) && start) || timeout) begin
            buf_q     <= '0;
            fill_cnt  <= '0;
            aad_len   <= '0;
            pld_len   <= '0;
            last_seen <= 1'b0;
         end else if (accept) begin
            buf_q     <= buf_fill;
            fill_cnt  <= cnt_next;
            // An empty closing block moves straight to the next segment, so the
            // new segment must not inherit the last flag.
            last_seen <= s_last && !empty_close;
            if (state_q == AAD_FILL) aad_len <= aad_len + 64'(pop);
            else                     pld_len <= pld_len + 64'(pop);
         end else if (((state_q == AAD_SEND) && aad_ready) || ((state_q == PLD_SEND) && pld_ready)) begin
            buf_q    <= '0;
            fill_cnt <= '0;
         end else if ((state_q == AAD_WAIT) && aad_done && last_seen) begin
            last_seen <= 1'b0;
         end
      end
   end

`ifdef POLY_FEEDER_TIMEOUT_EN
   logic        in_wait, done_hit, err_q;
   logic [31:0] to_cnt;

   assign in_wait  = (state_q == AAD_WAIT) || (state_q == PLD_WAIT) || (state_q == LEN_WAIT);
   assign done_hit = ((state_q == AAD_WAIT) && aad_done) || ((state_q == PLD_WAIT) && pld_done) ||
                     ((state_q == LEN_WAIT) && lens_done);
   assign timeout  = in_wait && !done_hit && (to_cnt == 32'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst || !in_wait) to_cnt <= '0;
      else                 to_cnt <= to_cnt + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= timeout;
   end

   assign err = err_q;
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif

   assign mac_start  = mac_start_q;
   assign frame_done = frame_done_q;
   assign busy       = (state_q != IDLE);
   assign aad_valid  = (state_q == AAD_SEND);
   assign pld_valid  = (state_q == PLD_SEND);
   assign len_valid  = (state_q == LEN_SEND);
   assign aad_data   = aad_valid ? buf_q : '0;
   assign aad_keep   = aad_valid ? keep_mask : '0;
   assign pld_data   = pld_valid ? buf_q : '0;
   assign pld_keep   = pld_valid ? keep_mask : '0;
   assign len_block  = len_valid ? {pld_len, aad_len} : '0;

endmodule

// File: tb/tb_poly1305_block_feeder.sv
// Directed bench for poly1305_block_feeder with hand-computed blocks, keeps
// and length blocks. The timeout scenario runs when POLY_FEEDER_TIMEOUT_EN is set.
module tb_poly1305_block_feeder;
   logic         clk = 1'b0;
   logic         rst, start, s_valid, s_last, s_ready, mac_start;
   logic [31:0]  s_data;
   logic [3:0]   s_keep;
   logic         aad_valid, aad_ready, aad_done;
   logic [127:0] aad_data, pld_data, len_block;
   logic [15:0]  aad_keep, pld_keep;
   logic         pld_valid, pld_ready, pld_done;
   logic         len_valid, len_ready, lens_done;
   logic         busy, frame_done, err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   poly1305_block_feeder #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst), .start(start),
      .s_valid(s_valid), .s_data(s_data), .s_keep(s_keep), .s_last(s_last), .s_ready(s_ready),
      .mac_start(mac_start),
      .aad_valid(aad_valid), .aad_data(aad_data), .aad_keep(aad_keep), .aad_ready(aad_ready), .aad_done(aad_done),
      .pld_valid(pld_valid), .pld_data(pld_data), .pld_keep(pld_keep), .pld_ready(pld_ready), .pld_done(pld_done),
      .len_valid(len_valid), .len_block(len_block), .len_ready(len_ready), .lens_done(lens_done),
      .busy(busy), .frame_done(frame_done), .err(err)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bound_fail(input string tag);
      checks++;
      errors++;
      $display("FAIL %s wait bound expired", tag);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] pw(input int i);
      return 32'h11223344 ^ (32'(i) * 32'h01010101);
   endfunction

   task automatic push(input logic [31:0] d, input logic [3:0] k, input logic l);
      int n;
      n = 0;
      s_valid = 1'b1; s_data = d; s_keep = k; s_last = l;
      while (!s_ready && n < 50) begin
         tick();
         n++;
      end
      if (!s_ready) bound_fail("push");
      else tick();
      s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0;
   endtask

   task automatic start_frame(input string tag);
      start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, "_mac_start"}, mac_start, 1'b1);
      check({tag, "_busy"}, busy, 1'b1);
      check({tag, "_sready"}, s_ready, 1'b1);
   endtask

   task automatic take_blk(input string tag, input bit is_pld, input logic [127:0] ed, input logic [15:0] ek);
      int n;
      n = 0;
      while (!(is_pld ? pld_valid : aad_valid) && n < 50) begin
         tick();
         n++;
      end
      check({tag, "_valid"}, is_pld ? pld_valid : aad_valid, 1'b1);
      check({tag, "_data"}, is_pld ? pld_data : aad_data, ed);
      check({tag, "_keep"}, is_pld ? pld_keep : aad_keep, ek);
      check({tag, "_sready_send"}, s_ready, 1'b0);
      if (is_pld) pld_ready = 1'b1;
      else        aad_ready = 1'b1;
      tick();
      aad_ready = 1'b0;
      pld_ready = 1'b0;
      check({tag, "_valid_drop"}, is_pld ? pld_valid : aad_valid, 1'b0);
   endtask

   task automatic pulse_done(input bit is_pld);
      if (is_pld) pld_done = 1'b1;
      else        aad_done = 1'b1;
      tick();
      aad_done = 1'b0;
      pld_done = 1'b0;
   endtask

   task automatic take_len(input string tag, input logic [127:0] exp);
      int n;
      n = 0;
      while (!len_valid && n < 50) begin
         tick();
         n++;
      end
      check({tag, "_len_valid"}, len_valid, 1'b1);
      check({tag, "_len_block"}, len_block, exp);
      len_ready = 1'b1;
      tick();
      len_ready = 1'b0;
      check({tag, "_len_drop"}, len_valid, 1'b0);
      check({tag, "_busy_wait"}, busy, 1'b1);
      lens_done = 1'b1;
      tick();
      lens_done = 1'b0;
      check({tag, "_frame_done"}, frame_done, 1'b1);
      check({tag, "_busy_end"}, busy, 1'b0);
      tick();
      check({tag, "_frame_done_pulse"}, frame_done, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   initial begin
      logic [127:0] exp_blk;
      rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0;
      aad_ready = 1'b0; aad_done = 1'b0; pld_ready = 1'b0; pld_done = 1'b0;
      len_ready = 1'b0; lens_done = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("rst_busy", busy, 1'b0);
      check("rst_sready", s_ready, 1'b0);
      check("rst_valids", {aad_valid, pld_valid, len_valid}, 3'b000);
      check("rst_pulses", {mac_start, frame_done, err}, 3'b000);
      check("rst_aad_data", aad_data, 128'h0);
      check("rst_len_block", len_block, 128'h0);

      // AAD 12 bytes + payload 16 bytes; start and pld_done mid-fill are ignored.
      start_frame("t1");
      push(32'h03020100, 4'hF, 1'b0);
      start = 1'b1;
      push(32'h07060504, 4'hF, 1'b0);
      start = 1'b0;
      check("t1_start_ignored", mac_start, 1'b0);
      push(32'h0b0a0908, 4'hF, 1'b1);
      take_blk("t1_aad", 1'b0, {32'h0, 32'h0b0a0908, 32'h07060504, 32'h03020100}, 16'h0FFF);
      pulse_done(1'b0);
      push(32'h13121110, 4'hF, 1'b0);
      pld_done = 1'b1;
      push(32'h17161514, 4'hF, 1'b0);
      pld_done = 1'b0;
      check("t1_fill_done_ignored", s_ready, 1'b1);
      push(32'h1b1a1918, 4'hF, 1'b0);
      push(32'h1f1e1d1c, 4'hF, 1'b1);
      take_blk("t1_pld", 1'b1, {32'h1f1e1d1c, 32'h1b1a1918, 32'h17161514, 32'h13121110}, 16'hFFFF);
      pulse_done(1'b1);
      take_len("t1", {64'd16, 64'd12});

      // Empty AAD then 4-byte payload.
      start_frame("t2");
      push(32'h12345678, 4'h0, 1'b1);
      check("t2_no_aad_valid", aad_valid, 1'b0);
      check("t2_pld_fill", s_ready, 1'b1);
      push(32'hdeadbeef, 4'hF, 1'b1);
      take_blk("t2_pld", 1'b1, {96'h0, 32'hdeadbeef}, 16'h000F);
      pulse_done(1'b1);
      take_len("t2", {64'd4, 64'd0});

      // AAD 4 bytes, payload 33 bytes across three blocks.
      start_frame("t3");
      push(32'ha0a1a2a3, 4'hF, 1'b1);
      take_blk("t3_aad", 1'b0, {96'h0, 32'ha0a1a2a3}, 16'h000F);
      pulse_done(1'b0);
      for (int b = 0; b < 2; b++) begin
         for (int j = 0; j < 4; j++) push(pw(4*b + j), 4'hF, 1'b0);
         exp_blk = {pw(4*b + 3), pw(4*b + 2), pw(4*b + 1), pw(4*b)};
         take_blk($sformatf("t3_pld%0d", b), 1'b1, exp_blk, 16'hFFFF);
         if (b == 0) begin
            for (int c = 0; c < 3; c++) begin
               tick();
               check("t3_hold_no_valid", pld_valid, 1'b0);
               check("t3_hold_sready", s_ready, 1'b0);
            end
         end
         pulse_done(1'b1);
      end
      push(32'hAABBCC55, 4'h1, 1'b1);
      take_blk("t3_pld2", 1'b1, 128'h55, 16'h0001);
      pulse_done(1'b1);
      take_len("t3", {64'd33, 64'd4});

      // Back-pressure on AAD, then ready and done in the same cycle.
      start_frame("t4");
      push(32'hcafef00d, 4'hF, 1'b1);
      for (int c = 0; c < 5; c++) begin
         check("t4_stall_valid", aad_valid, 1'b1);
         check("t4_stall_data", aad_data, {96'h0, 32'hcafef00d});
         check("t4_stall_keep", aad_keep, 16'h000F);
         check("t4_stall_sready", s_ready, 1'b0);
         tick();
      end
      aad_ready = 1'b1;
      aad_done  = 1'b1;
      tick();
      aad_ready = 1'b0;
      aad_done  = 1'b0;
      check("t4_hs_drop", aad_valid, 1'b0);
      tick();
      check("t4_done_ignored", s_ready, 1'b0);
      tick();
      check("t4_still_wait", s_ready, 1'b0);
      pulse_done(1'b0);
      check("t4_pld_fill", s_ready, 1'b1);
      push(32'h01020304, 4'hF, 1'b1);
      take_blk("t4_pld", 1'b1, {96'h0, 32'h01020304}, 16'h000F);
      pulse_done(1'b1);
      take_len("t4", {64'd4, 64'd4});

      // Reset during payload fill, then a clean 4B/4B frame.
      start_frame("t5");
      push(32'h11111111, 4'hF, 1'b1);
      take_blk("t5_aad", 1'b0, {96'h0, 32'h11111111}, 16'h000F);
      pulse_done(1'b0);
      push(32'h99999999, 4'hF, 1'b0);
      check("t5_mid_fill", s_ready, 1'b1);
      rst = 1'b1;
      tick();
      check("t5_rst_busy", busy, 1'b0);
      check("t5_rst_sready", s_ready, 1'b0);
      check("t5_rst_valids", {aad_valid, pld_valid, len_valid}, 3'b000);
      check("t5_rst_pld_data", pld_data, 128'h0);
      rst = 1'b0;
      tick();
      start_frame("t5b");
      push(32'h22222222, 4'hF, 1'b1);
      take_blk("t5b_aad", 1'b0, {96'h0, 32'h22222222}, 16'h000F);
      pulse_done(1'b0);
      push(32'h33333333, 4'hF, 1'b1);
      take_blk("t5b_pld", 1'b1, {96'h0, 32'h33333333}, 16'h000F);
      pulse_done(1'b1);
      take_len("t5b", {64'd4, 64'd4});

`ifdef POLY_FEEDER_TIMEOUT_EN
      // pld_done withheld: err exactly 8 cycles after entering PLD_WAIT.
      start_frame("t6");
      push(32'h44444444, 4'hF, 1'b1);
      take_blk("t6_aad", 1'b0, {96'h0, 32'h44444444}, 16'h000F);
      pulse_done(1'b0);
      push(32'h55555555, 4'hF, 1'b1);
      take_blk("t6_pld", 1'b1, {96'h0, 32'h55555555}, 16'h000F);
      for (int c = 1; c < 8; c++) begin
         tick();
         check("t6_no_err_yet", err, 1'b0);
      end
      tick();
      check("t6_err", err, 1'b1);
      check("t6_busy", busy, 1'b0);
      check("t6_valids", {aad_valid, pld_valid, len_valid}, 3'b000);
      tick();
      check("t6_err_pulse", err, 1'b0);
      start_frame("t6b");
`else
      check("final_err_tied", err, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
